wb_indirect_buf_port: RTL and testbench



---
 rtl/wb_indirect_buf_port.sv | 124 ++++++++++++
 tb/tb_wb_indirect_buf_port.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_indirect_buf_port.sv
// Wishbone classic slave giving the host indirect access to a 32-bit buffer
// through an ADDR pointer register and an auto-incrementing DATA window.
//
// state  | meaning
// IDLE   | waiting for cyc&stb; writes and register reads are handled here
// RD_MEM | registered buffer read in flight, captured into wb_dat_o
// ACK    | ack issued at the exit edge, pointer bumped for DATA accesses
module wb_indirect_buf_port #(
  parameter int unsigned g_ADDR_WIDTH = 10,
  parameter logic [31:0] g_INIT_VALUE = 32'h0000_0000
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_n_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [1:0]              wb_adr_i,
  input  logic [3:0]              wb_sel_i,
  input  logic [31:0]             wb_dat_i,
  output logic [31:0]             wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_stall_o,
  output logic [g_ADDR_WIDTH-1:0] ptr_o
);

  localparam int unsigned            c_DEPTH    = 2 ** g_ADDR_WIDTH;
  localparam logic [g_ADDR_WIDTH-1:0] c_PTR_MAX = '1;
  localparam logic [4:0]             c_AW_FIELD = 5'(g_ADDR_WIDTH);

  localparam logic [1:0] c_ADR_ADDR   = 2'd0;
  localparam logic [1:0] c_ADR_DATA   = 2'd1;
  localparam logic [1:0] c_ADR_STATUS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t                  state;
  logic [g_ADDR_WIDTH-1:0] ptr;
  logic                    wrap;
  logic                    data_acc;
  logic                    aborted;
  logic                    req;
  logic                    mem_wr;
  logic [31:0]             reg_rd;
  logic [31:0]             mem_q;

  // Contents come from the configuration image only; reset leaves them alone.
  logic [31:0] mem [c_DEPTH] = '{default: g_INIT_VALUE};

  assign req    = wb_cyc_i & wb_stb_i;
  assign mem_wr = (state == IDLE) & req & wb_we_i & (wb_adr_i == c_ADR_DATA);

  always_ff @(posedge clk_sys_i) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_wr && wb_sel_i[b]) mem[ptr][8*b +: 8] <= wb_dat_i[8*b +: 8];
    end
    mem_q <= mem[ptr];
  end

  always_comb begin
    reg_rd = '0;
    case (wb_adr_i)
      c_ADR_ADDR:   reg_rd = 32'(ptr);
      c_ADR_STATUS: reg_rd = {11'd0, c_AW_FIELD, 15'd0, wrap};
      default:      reg_rd = '0;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      ptr      <= '0;
      wrap     <= 1'b0;
      data_acc <= 1'b0;
      aborted  <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            data_acc <= (wb_adr_i == c_ADR_DATA);
            aborted  <= 1'b0;
            if (wb_we_i) begin
              if (wb_adr_i == c_ADR_ADDR) begin
                ptr  <= wb_dat_i[g_ADDR_WIDTH-1:0];
                wrap <= 1'b0;
              end
              state <= ACK;
            end else if (wb_adr_i == c_ADR_DATA) begin
              state <= RD_MEM;
            end else begin
              wb_dat_o <= reg_rd;
              state    <= ACK;
            end
          end
        end
        RD_MEM: begin
          wb_dat_o <= mem_q;
          if (!wb_cyc_i) aborted <= 1'b1;
          state <= ACK;
        end
        ACK: begin
          // A dropped cycle hides the ack but the started DATA access still counts.
          wb_ack_o <= wb_cyc_i & ~aborted;
          if (data_acc) begin
            ptr <= ptr + 1'b1;
            if (ptr == c_PTR_MAX) wrap <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb_stall_o = (state != IDLE);
  assign ptr_o      = ptr;

endmodule

// File: tb/tb_wb_indirect_buf_port.sv
// Directed bench for wb_indirect_buf_port: a register/buffer model predicts
// ack, stall, pointer and read data every cycle, plus literal expectations.
module tb_wb_indirect_buf_port;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cyc, stb, we;
  logic [1:0]    adr;
  logic [3:0]    sel;
  logic [31:0]   dat_w;
  logic [31:0]   dat_r;
  logic          ack, stall;
  logic [AW-1:0] ptr;

  wb_indirect_buf_port #(.g_ADDR_WIDTH(AW), .g_INIT_VALUE(32'h0)) dut (
    .clk_sys_i (clk),
    .rst_n_i   (rst_n),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_adr_i  (adr),
    .wb_sel_i  (sel),
    .wb_dat_i  (dat_w),
    .wb_dat_o  (dat_r),
    .wb_ack_o  (ack),
    .wb_stall_o(stall),
    .ptr_o     (ptr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the block as the host sees it.
  logic [31:0]   m_mem [1 << AW];
  logic [AW-1:0] m_ptr;
  logic          m_wrap;
  logic          exp_ack, exp_stall, exp_rd;
  logic [31:0]   exp_dat;
  logic          chk_en;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {{(32-AW){1'b0}}, m_ptr};
      2'd1:    return m_mem[m_ptr];
      2'd2:    return {11'd0, 5'd10, 15'd0, m_wrap};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
    if (a == 2'd0) begin
      m_ptr  = d[AW-1:0];
      m_wrap = 1'b0;
    end else if (a == 2'd1) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_mem[m_ptr][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic model_inc();
    if (m_ptr == {AW{1'b1}}) m_wrap = 1'b1;
    m_ptr = m_ptr + 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", 32'(ack), 32'(exp_ack));
      check("stall", 32'(stall), 32'(exp_stall));
      check("ptr", 32'(ptr), 32'(m_ptr));
      if (exp_ack && exp_rd) check("rdata", dat_r, exp_dat);
    end
  end

  task automatic access(input logic w, input logic [1:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd);
    logic [31:0] v;
    int lat;
    lat = (!w && a == 2'd1) ? 2 : 1;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    v = model_read(a);
    @(posedge clk);
    if (w) model_write(a, s, d);
    exp_stall = 1'b1;
    repeat (lat - 1) @(posedge clk);
    @(posedge clk);
    exp_stall = 1'b0;
    exp_ack   = 1'b1;
    exp_rd    = !w;
    exp_dat   = v;
    if (a == 2'd1) model_inc();
    @(negedge clk);
    rd = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk);
    exp_ack = 1'b0;
    exp_rd  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    access(1'b1, a, 4'hF, d, unused_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    for (int i = 0; i < (1 << AW); i++) m_mem[i] = 32'h0;
    m_ptr = '0; m_wrap = 1'b0;
    exp_ack = 1'b0; exp_stall = 1'b0; exp_rd = 1'b0; exp_dat = '0;
    chk_en = 1'b0;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dat", dat_r, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_ptr", 32'(ptr), 32'h0);
    chk_en = 1'b1;

    // 1: register reads after reset
    access(1'b0, 2'd2, 4'hF, 32'h0, r); check("t1_status", r, 32'h000A_0000);
    access(1'b0, 2'd0, 4'hF, 32'h0, r); check("t1_addr", r, 32'h0);

    // 2: sequential write then read back
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd0); wr(2'd1, 32'd1); wr(2'd1, 32'd2);
    wr(2'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 2'd1, 4'hF, 32'h0, r);
      check("t2_rd", r, 32'(i));
    end
    check("t2_ptr", 32'(ptr), 32'd3);

    // 3: byte-lane merge
    wr(2'd0, 32'd5); wr(2'd1, 32'hAABB_CCDD);
    wr(2'd0, 32'd5); access(1'b1, 2'd1, 4'b0101, 32'h1122_3344, r);
    wr(2'd0, 32'd5); access(1'b0, 2'd1, 4'hF, 32'h0, r);
    check("t3_merge", r, 32'hAA22_CC44);

    // 4: pointer wrap and sticky flag
    wr(2'd0, 32'h3FF); wr(2'd1, 32'h0000_DEAD); wr(2'd1, 32'h0000_BEEF);
    access(1'b0, 2'd2, 4'hF, 32'h0, r); check("t4_wrap_set", r, 32'h000A_0001);
    check("t4_ptr", 32'(ptr), 32'd1);
    wr(2'd2, 32'h0);
    access(1'b0, 2'd2, 4'hF, 32'h0, r); check("t4_status_wr_ignored", r, 32'h000A_0001);
    wr(2'd0, 32'd0);
    access(1'b0, 2'd1, 4'hF, 32'h0, r); check("t4_mem0", r, 32'h0000_BEEF);
    access(1'b0, 2'd2, 4'hF, 32'h0, r); check("t4_wrap_clr", r, 32'h000A_0000);

    // unmapped offset, ADDR upper bits, sel=0000 write
    wr(2'd3, 32'hFFFF_FFFF);
    access(1'b0, 2'd3, 4'hF, 32'h0, r); check("unmapped_rd", r, 32'h0);
    wr(2'd0, 32'h0001_2345);
    access(1'b0, 2'd0, 4'hF, 32'h0, r); check("addr_trunc", r, 32'h0000_0345);
    wr(2'd1, 32'h0BAD_F00D);
    wr(2'd0, 32'h345);
    access(1'b1, 2'd1, 4'b0000, 32'hFFFF_FFFF, r);
    check("sel0_ptr", 32'(ptr), 32'h346);
    wr(2'd0, 32'h345);
    access(1'b0, 2'd1, 4'hF, 32'h0, r); check("sel0_keep", r, 32'h0BAD_F00D);

    // 5: cycle dropped during RD_MEM
    wr(2'd0, 32'd7); wr(2'd1, 32'h0000_0777); wr(2'd1, 32'h0000_0888);
    wr(2'd0, 32'd7);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd1;
    @(posedge clk); exp_stall = 1'b1;
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
    @(posedge clk);
    @(posedge clk); exp_stall = 1'b0; model_inc();
    @(negedge clk); check("t5_ptr", 32'(ptr), 32'd8);
    access(1'b0, 2'd1, 4'hF, 32'h0, r); check("t5_next", r, 32'h0000_0888);

    // 6: reset during the ack of a DATA write
    wr(2'd0, 32'd3);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd1; sel = 4'hF; dat_w = 32'h5A5A_1234;
    @(posedge clk); model_write(2'd1, 4'hF, 32'h5A5A_1234); exp_stall = 1'b1;
    @(posedge clk); exp_stall = 1'b0; exp_ack = 1'b1; exp_rd = 1'b0; model_inc();
    @(negedge clk);
    #2 rst_n = 1'b0;
    m_ptr = '0; m_wrap = 1'b0; exp_ack = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #1;
    check("t6_ack_async", 32'(ack), 32'h0);
    check("t6_ptr_async", 32'(ptr), 32'h0);
    check("t6_dat_rst", dat_r, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wr(2'd0, 32'd3);
    access(1'b0, 2'd1, 4'hF, 32'h0, r); check("t6_kept", r, 32'h5A5A_1234);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
